// File: rtl/irq_arbiter_if.sv
// Request/acknowledge bus between the interrupt arbiter (master) and the core's IRQ unit (slave).
interface irq_arbiter_if #(
  parameter int NIRQ = 32,
  parameter int IDW  = 5
);
  logic            irq_req;
  logic [NIRQ-1:0] irq_vec;
  logic [IDW-1:0]  irq_id;
  logic            irq_ack;
  logic            irq_done;
  logic            core_ready;

  modport master (output irq_req, irq_vec, irq_id, input irq_ack, irq_done, core_ready);
  modport slave  (input irq_req, irq_vec, irq_id, output irq_ack, irq_done, core_ready);
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt front end: synchronises and edge-detects raw lines, keeps them pending under a
// mask and offers the highest-priority one to the core over a req/ack bus, one at a time.
module irq_arbiter #(
  parameter int NIRQ    = 32,
  parameter int IDW     = 5,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] i_irq_in,
  input  logic            i_mask_we,
  input  logic [NIRQ-1:0] i_mask_wdata,
  input  logic            i_clr_valid,
  input  logic [NIRQ-1:0] i_clr_vec,
  irq_arbiter_if.master   bus,
  output logic [NIRQ-1:0] o_mask,
  output logic [NIRQ-1:0] o_pending,
  output logic            o_active,
  output logic            o_timeout_flag
);

  localparam int WW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WW-1:0]   WAIT_ONE  = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0]   WAIT_MAX  = {WW{1'b1}};
  localparam logic [WW-1:0]   WAIT_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : {WW{1'b0}};
  localparam logic [NIRQ-1:0] VEC_ONE   = {{(NIRQ-1){1'b0}}, 1'b1};
  localparam logic [NIRQ-1:0] VEC_ZERO  = {NIRQ{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  logic [NIRQ-1:0] r_sync1, r_sync2, r_hist;
  logic [1:0]      r_prime;
  logic [NIRQ-1:0] r_pending, r_mask;
  logic            r_req, r_active, r_tflag;
  logic [NIRQ-1:0] r_vec;
  logic [IDW-1:0]  r_id;
  logic [WW-1:0]   r_wait;

  logic [NIRQ-1:0] w_set, w_clear, w_cand, w_win_vec;
  logic [IDW-1:0]  w_win_id;
  logic            w_any, w_ack_req, w_withdraw;

  // Edges count only once the pipeline is primed: a line already high at reset release is a level.
  assign w_set      = (r_prime == 2'd3) ? (r_sync2 & ~r_hist) : VEC_ZERO;
  assign w_ack_req  = (r_state == S_REQ) && bus.irq_ack;
  assign w_clear    = (i_clr_valid ? i_clr_vec : VEC_ZERO) | (w_ack_req ? r_vec : VEC_ZERO);
  assign w_cand     = r_pending & r_mask;
  assign w_any      = |w_cand;
  assign w_win_vec  = w_cand & (~w_cand + VEC_ONE);
  assign w_withdraw = i_mask_we && ((i_mask_wdata & r_vec) == VEC_ZERO);

  // Binary encode of the one-hot winner.
  always_comb begin
    w_win_id = {IDW{1'b0}};
    for (int i = 0; i < NIRQ; i++) begin
      w_win_id = w_win_id | ({IDW{w_win_vec[i]}} & IDW'(i));
    end
  end

  // Synchronisers, edge history, pending and mask registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= VEC_ZERO;
      r_sync2   <= VEC_ZERO;
      r_hist    <= VEC_ZERO;
      r_prime   <= 2'd0;
      r_pending <= VEC_ZERO;
      r_mask    <= VEC_ZERO;
    end else begin
      r_sync1   <= i_irq_in;
      r_sync2   <= r_sync1;
      r_hist    <= r_sync2;
      if (r_prime != 2'd3) r_prime <= r_prime + 2'd1;
      r_pending <= (r_pending & ~w_clear) | w_set;
      if (i_mask_we) r_mask <= i_mask_wdata;
    end
  end

  // Request/service state machine with registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_vec    <= VEC_ZERO;
      r_id     <= {IDW{1'b0}};
      r_active <= 1'b0;
      r_tflag  <= 1'b0;
      r_wait   <= {WW{1'b0}};
    end else begin
      // A timeout raised in this same cycle overrides the mask-write clear below.
      if (i_mask_we) r_tflag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && bus.core_ready) begin
            r_vec   <= w_win_vec;
            r_id    <= w_win_id;
            r_req   <= 1'b1;
            r_wait  <= {WW{1'b0}};
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.irq_ack) begin
            r_req    <= 1'b0;
            r_active <= 1'b1;
            r_state  <= S_SERVICE;
          end else if (w_withdraw) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end else if ((TIMEOUT != 0) && (r_wait == WAIT_LAST)) begin
            r_req   <= 1'b0;
            r_tflag <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_wait != WAIT_MAX) begin
            r_wait <= r_wait + WAIT_ONE;
          end
        end
        S_SERVICE: begin
          if (bus.irq_done) begin
            r_active <= 1'b0;
            r_vec    <= VEC_ZERO;
            r_id     <= {IDW{1'b0}};
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_req    <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_req    = r_req;
  assign bus.irq_vec    = r_vec;
  assign bus.irq_id     = r_id;
  assign o_mask         = r_mask;
  assign o_pending      = r_pending;
  assign o_active       = r_active;
  assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: directed scenarios, then random traffic checked
// against a cycle-level reference built from the interrupt rules.
module tb_irq_arbiter;
  localparam int N   = 32;
  localparam int IDW = 5;
  localparam int TO  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] mask_wdata = '0;
  logic [N-1:0] clr_vec = '0;
  logic         mask_we = 1'b0, clr_valid = 1'b0, ready = 1'b0, ack = 1'b0, done = 1'b0;
  logic [N-1:0] o_mask, o_pending;
  logic         o_active, o_timeout_flag;

  irq_arbiter_if #(.NIRQ(N), .IDW(IDW)) bus ();
  assign bus.irq_ack    = ack;
  assign bus.irq_done   = done;
  assign bus.core_ready = ready;

  irq_arbiter #(.NIRQ(N), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_irq_in(irq_in), .i_mask_we(mask_we), .i_mask_wdata(mask_wdata),
    .i_clr_valid(clr_valid), .i_clr_vec(clr_vec), .bus(bus), .o_mask(o_mask),
    .o_pending(o_pending), .o_active(o_active), .o_timeout_flag(o_timeout_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  // Reference state: samples of irq_in at the last three edges, request bookkeeping.
  logic [N-1:0] m_pend, m_mask, m_s1, m_s2, m_s3;
  int           m_edges, m_id, m_wait;
  bit           m_req_on, m_svc, m_tflag;
  logic         prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_s1 = '0; m_s2 = '0; m_s3 = '0;
    m_edges = 0; m_id = 0; m_wait = 0;
    m_req_on = 1'b0; m_svc = 1'b0; m_tflag = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge of the reference, using the inputs applied during the cycle.
  task automatic model_edge();
    logic [N-1:0] set_v, clr_v;
    int win;
    if (!rst) return;
    m_edges++;
    set_v = (m_edges >= 4) ? (m_s2 & ~m_s3) : '0;
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
    clr_v = clr_valid ? clr_vec : '0;
    if (m_req_on && ack) clr_v[m_id] = 1'b1;
    if (mask_we) m_tflag = 1'b0;
    if (m_req_on) begin
      if (ack) begin
        m_req_on = 1'b0; m_svc = 1'b1;
      end else if (mask_we && !mask_wdata[m_id]) begin
        m_req_on = 1'b0;
      end else if (m_wait + 1 == TO) begin
        m_req_on = 1'b0; m_tflag = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (m_svc) begin
      if (done) m_svc = 1'b0;
    end else if (win >= 0 && ready) begin
      m_req_on = 1'b1; m_id = win; m_wait = 0;
      exp_q.push_back(win);
    end
    m_pend = (m_pend & ~clr_v) | set_v;
    if (mask_we) m_mask = mask_wdata;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq_in;
  endtask

  // Monitor: per-cycle state compare plus scoreboard pop on each new request.
  always @(negedge clk) begin
    if (rst) begin
      logic [N-1:0] ev;
      int e;
      chk("pending", o_pending, m_pend);
      chk("mask", o_mask, m_mask);
      chk("irq_req", 32'(bus.irq_req), 32'(m_req_on));
      chk("active", 32'(o_active), 32'(m_svc));
      chk("timeout_flag", 32'(o_timeout_flag), 32'(m_tflag));
      if (bus.irq_req && !prev_req) begin
        chk("req_without_expected", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          ev = '0;
          ev[e] = 1'b1;
          chk("sb_irq_id", 32'(bus.irq_id), 32'(e));
          chk("sb_irq_vec", bus.irq_vec, ev);
        end
      end
    end
    prev_req <= rst ? bus.irq_req : 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset a little after an edge; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_pending", o_pending, 32'h0);
    chk("rst_mask", o_mask, 32'h0);
    chk("rst_req", 32'(bus.irq_req), 32'd0);
    chk("rst_vec", bus.irq_vec, 32'h0);
    chk("rst_id", 32'(bus.irq_id), 32'd0);
    chk("rst_active", 32'(o_active), 32'd0);
    chk("rst_tflag", 32'(o_timeout_flag), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    ticks(2);

    // Single source: pending, request, ack, done.
    ready = 1'b1;
    write_mask(32'h6);
    irq_in[2] = 1'b1; ticks(3); irq_in[2] = 1'b0;
    chk("t1_pending", o_pending, 32'h4);
    chk("t1_req_not_yet", 32'(bus.irq_req), 32'd0);
    tick();
    chk("t1_req", 32'(bus.irq_req), 32'd1);
    chk("t1_id", 32'(bus.irq_id), 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_pending_clr", o_pending, 32'h0);
    chk("t1_active", 32'(o_active), 32'd1);
    done = 1'b1; tick(); done = 1'b0;
    chk("t1_done", 32'(o_active), 32'd0);

    // Two simultaneous sources: lower index first.
    irq_in[1] = 1'b1; irq_in[2] = 1'b1; ticks(3);
    chk("t2_pending", o_pending, 32'h6);
    tick();
    chk("t2_first_id", 32'(bus.irq_id), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_pending_mid", o_pending, 32'h4);
    done = 1'b1; tick(); done = 1'b0;
    tick();
    chk("t2_second_id", 32'(bus.irq_id), 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_pending_end", o_pending, 32'h0);
    done = 1'b1; tick(); done = 1'b0;
    irq_in = '0; ticks(2);

    // Mask withdraw keeps pending, unmask reissues.
    irq_in[2] = 1'b1; ticks(4);
    chk("t3_req", 32'(bus.irq_id), 32'd2);
    write_mask(32'h0);
    chk("t3_withdrawn", 32'(bus.irq_req), 32'd0);
    chk("t3_kept", o_pending, 32'h4);
    write_mask(32'h4);
    tick();
    chk("t3_reissue", 32'(bus.irq_req), 32'd1);
    chk("t3_reissue_id", 32'(bus.irq_id), 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    irq_in = '0;

    // Timeout after TO request cycles, reissue, mask write clears the flag.
    write_mask(32'h6);
    irq_in[1] = 1'b1; ticks(4);
    chk("t4_req", 32'(bus.irq_req), 32'd1);
    ticks(TO);
    chk("t4_timeout_drop", 32'(bus.irq_req), 32'd0);
    chk("t4_flag", 32'(o_timeout_flag), 32'd1);
    tick();
    chk("t4_reissue", 32'(bus.irq_req), 32'd1);
    write_mask(32'h6);
    chk("t4_flag_clr", 32'(o_timeout_flag), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    irq_in = '0; ticks(2);

    // Clear colliding with a new edge: set wins.
    irq_in[3] = 1'b1; ticks(2);
    clr_valid = 1'b1; clr_vec = 32'h8; tick();
    chk("t5_set_wins", 32'(o_pending[3]), 32'd1);
    tick(); clr_valid = 1'b0; clr_vec = '0;
    chk("t5_cleared", 32'(o_pending[3]), 32'd0);
    irq_in = '0; ticks(2);

    // Reset during service; held-high line needs a fresh edge afterwards.
    write_mask(32'h20);
    irq_in[5] = 1'b1; ticks(4);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_in_service", 32'(o_active), 32'd1);
    do_reset();
    ticks(6);
    chk("t6_level_ignored", o_pending, 32'h0);
    irq_in[5] = 1'b0; ticks(2);
    irq_in[5] = 1'b1; ticks(3);
    chk("t6_new_edge", o_pending, 32'h20);
    irq_in = '0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int k;
      if (c == 1500) do_reset();
      if ($urandom_range(3) == 0) begin
        k = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : int'($urandom_range(7));
        irq_in[k] = ~irq_in[k];
      end
      mask_we    = ($urandom_range(15) == 0);
      mask_wdata = ($urandom_range(1) == 0) ? $urandom() : 32'hFF;
      clr_valid  = ($urandom_range(7) == 0);
      clr_vec    = $urandom() & $urandom();
      ready      = ($urandom_range(3) != 0);
      ack        = ($urandom_range(2) == 0);
      done       = ($urandom_range(2) == 0);
      tick();
    end
    mask_we = 1'b0; clr_valid = 1'b0; ack = 1'b0; done = 1'b0;
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Front-end controller for the core's IRQ unit: collects up to NIRQ raw interrupt lines, synchronises and edge-detects them, and holds them as pending bits under a software mask.
- Picks the highest-priority serviceable source and presents it to the IRQ unit as a one-hot vector with a req/ack handshake.
- Tracks one in-service interrupt until return, and withdraws stale requests on mask change or timeout.

Parameters:
- NIRQ, 32, number of interrupt sources; bit 0 highest priority, bit NIRQ-1 lowest.
- IDW, 5, width of the encoded source id; must be >= clog2(NIRQ).
- TIMEOUT, 255, cycles REQ may wait for irq_ack before it is withdrawn; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- irq_in  in  NIRQ  raw interrupt lines, asynchronous, rising-edge triggered
- mask_we  in  1  write strobe for mask_wdata
- mask_wdata  in  NIRQ  new enable mask (1 = enabled)
- clr_valid  in  1  strobe: clear pending bits given in clr_vec
- clr_vec  in  NIRQ  pending bits to clear (driven from the IRQ unit outirr)
- core_ready  in  1  core at an instruction boundary and able to take an interrupt
- irq_ack  in  1  core has saved the PC and entered the handler
- irq_done  in  1  handler returned (RETIRQ executed)
- irq_req  out  1  interrupt request to the core
- irq_vec  out  NIRQ  one-hot selected source, valid while irq_req=1
- irq_id  out  IDW  binary index of irq_vec
- mask  out  NIRQ  current mask register
- pending  out  NIRQ  pending register
- active  out  1  handler in service
- timeout_flag  out  1  sticky; set on request timeout, cleared by a mask write

Behaviour:
- Reset (async, rst=0): all synchroniser stages, pending, mask, irq_req, irq_vec, irq_id, active, timeout_flag and the wait counter go to 0; FSM goes to IDLE.
- Synchroniser: 2-FF stage per line plus one history FF.
  - A rising edge on the synchronised line sets its pending bit.
  - irq_in going high before edge k gives pending visible after edge k+2.
  - A level held high sets pending only once.
- Pending update each cycle: pending_next = (pending & ~clear) | set_edge.
  - clear = (clr_valid ? clr_vec : 0) | (irq_ack in REQ ? irq_vec : 0).
  - A set on the same bit in the same cycle wins over a clear.
- Mask: written on mask_we the same edge. Masked bits still latch as pending but are never selected.
- Selection: cand = pending & mask; winner = lowest set index (fixed priority), computed combinationally.
- FSM states and transitions:
  - IDLE: if cand != 0 and core_ready=1, register irq_vec = one-hot winner and irq_id = index, set irq_req=1, clear the wait counter, go to REQ. irq_req is high the cycle after the condition is seen.
  - REQ: irq_vec and irq_id stay frozen; a higher-priority arrival does not preempt.
    - irq_ack=1: clear that pending bit, irq_req=0, active=1, go to SERVICE. irq_vec/irq_id keep their value.
    - Selected bit masked by mask_we (ack not present): irq_req=0, go to IDLE, pending unchanged.
    - Wait counter reaches TIMEOUT (TIMEOUT != 0): irq_req=0, timeout_flag=1, go to IDLE, pending kept.
    - Priority when several apply in one cycle: ack > mask withdraw > timeout.
  - SERVICE: no new request is issued (no nesting).
    - irq_done=1: active=0, irq_vec=0, irq_id=0, go to IDLE.
    - A new request can be issued at the earliest one cycle after the cycle in which active falls.
    - irq_ack in SERVICE is ignored.
- irq_done outside SERVICE and irq_ack outside REQ are ignored.
- Wait counter: 8+ bits wide enough for TIMEOUT, counts cycles in REQ, saturates, reset on entering REQ.
- Mid-operation reset: everything returns to its reset values immediately; a handler in progress is lost.

Test Plan:
- Reset, then mask=0x0000_0006, pulse irq_in[2] (3 cycles), core_ready=1 -> pending=0x4 after 2 edges; irq_req=1, irq_vec=0x4, irq_id=2 one edge later; ack -> pending=0, active=1; irq_done -> active=0, IDLE.
- Simultaneous irq_in[1] and irq_in[2] with mask=0x6 -> irq_id=1 served first; after irq_done, irq_id=2 requested; pending goes 0x6 -> 0x4 -> 0.
- In REQ with irq_id=2, write mask=0x0 without ack -> irq_req=0 next edge, pending=0x4 retained; rewrite mask=0x4 -> request reissued with irq_id=2.
- TIMEOUT=4, never ack -> irq_req drops after 4 REQ cycles, timeout_flag=1, request reissued from IDLE; mask write clears timeout_flag.
- clr_valid with clr_vec=0x8 in the same cycle as a new edge on irq_in[3] -> pending[3]=1 (set wins); clr_valid alone -> pending[3]=0.
- Assert rst=0 during SERVICE -> active, irq_req, pending and mask all 0 asynchronously; held-high irq_in[5] does not set pending after release until a new rising edge.
